reservation_station: RTL and testbench
======================================

RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  RS_SIZE, 16, number of entries
  ROB_W, 5, ROB id width; id 0 = no dependency / operand ready
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
  clk  in  1  clock
  rst  in  1  reset, synchronous, active-high
  rdy  in  1  global ready; low = freeze
  rollback_sign_from_rob  in  1  flush all entries
  enable_sign_from_dsp  in  1  dispatch valid
  opnum_from_dsp  in  6  operation number
  V1_from_dsp / V2_from_dsp  in  32  operand values
  Q1_from_dsp / Q2_from_dsp  in  ROB_W  operand tags
  pc_from_dsp / imm_from_dsp  in  32  pc, immediate
  rob_id_from_dsp  in  ROB_W  destination tag
  valid_sign_from_rs_ex / valid_sign_from_ls_ex  in  1  CDB broadcast valid
  rob_id_from_rs_ex / rob_id_from_ls_ex  in  ROB_W  broadcast tag
  data_from_rs_ex / data_from_ls_ex  in  32  broadcast value
  full_sign_to_fch  out  1  stop-fetch hint
  enable_sign_to_ex  out  1  issue valid, registered
  opnum_to_ex  out  6  issued op
  V1_to_ex / V2_to_ex  out  32  issued operands
  pc_to_ex / imm_to_ex  out  32  issued pc, immediate
  rob_id_to_ex  out  ROB_W  issued tag

Function
REQ-003 SHALL keep per entry: busy, opnum, V1, V2, Q1, Q2, pc, imm, rob_id; operand is ready iff its Q == 0.
REQ-004 SHALL, on each rising edge with rdy=1 and no rollback, update all state; rdy=0 SHALL hold every register and output unchanged.
REQ-005 Dispatch: enable_sign_from_dsp=1 SHALL write the lowest-index entry not busy at the start of the cycle and set its busy.
REQ-006 Dispatch into a full station (all busy) is a protocol violation; the request SHALL be dropped with no state change.
REQ-007 Insert forwarding: if incoming Qx is nonzero and equals a valid broadcast tag in the same cycle, the entry SHALL store Qx=0 and Vx=broadcast data; rs_ex SHALL take precedence when both ports match.
REQ-008 Snoop: each busy entry with nonzero Qx equal to a valid broadcast tag SHALL capture that data and clear Qx in the same edge; both operands MAY resolve from different ports in one edge.
REQ-009 Issue: the lowest-index busy entry with Q1==0 and Q2==0 at the start of the cycle SHALL be registered onto the *_to_ex outputs with enable_sign_to_ex=1, and its busy SHALL be cleared at that edge.
REQ-010 If no entry is ready, enable_sign_to_ex SHALL be 0 next cycle; the data outputs SHALL hold their last values.
REQ-011 Latency: an entry dispatched with both operands ready at edge t SHALL be eligible for issue at edge t+1; an operand woken at edge t SHALL make the entry eligible at edge t+1 (one issue per cycle).
REQ-012 A slot freed by issue at edge t SHALL NOT be reused by a dispatch at edge t; it SHALL be available from edge t+1.
REQ-013 full_sign_to_fch SHALL be combinational from the registered occupancy count: 1 when count >= RS_SIZE-2. The 2-slot slack covers the one-cycle registered dispatch stage.
REQ-014 The occupancy count SHALL change by +1 on accepted dispatch, -1 on issue, and be unchanged when both occur; it SHALL saturate neither way because the stall from REQ-006 and REQ-013 keeps it in range.
REQ-015 Rollback: rollback_sign_from_rob=1 at an edge SHALL clear every busy, set count=0 and enable_sign_to_ex=0, and ignore a same-cycle dispatch and broadcasts; rollback SHALL take priority over rdy.

Reset
REQ-016 rst=1 at an edge SHALL clear all busy bits, count, and enable_sign_to_ex, and zero every *_to_ex data output; full_sign_to_fch SHALL read 0 after reset.
REQ-017 Reset SHALL take priority over rollback, dispatch, snoop, and rdy.
REQ-018 Entry payload fields other than busy need not be reset.

Verification
REQ-019 Dispatch ADD with Q1=Q2=0, V1=5, V2=7, rob_id=3 -> next edge enable_sign_to_ex=1, V1_to_ex=5, V2_to_ex=7, rob_id_to_ex=3.
REQ-020 Dispatch with Q1=4; two cycles later rs_ex broadcasts tag 4, data 0x10 -> issue occurs one edge after the broadcast with V1_to_ex=0x10.
REQ-021 Dispatch Q2=6 in the same cycle that ls_ex broadcasts tag 6, data 9 -> entry stored ready; issued next edge with V2_to_ex=9.
REQ-022 Fill 14 blocked entries -> full_sign_to_fch=1; dispatch 2 more -> accepted; a 17th dispatch -> dropped, count stays 16.
REQ-023 8 busy entries, then rollback together with a dispatch -> all busy cleared, count=0, no issue on the following cycle.
REQ-024 Entries 2 and 5 both become ready at the same edge -> entry 2 issues first and entry 5 issues one cycle later; with rdy=0 in between, all outputs are held.

Source files
------------

// File: rtl/reservation_station_if.sv
// Dispatch, CDB broadcast and issue bus of the reservation station.
interface reservation_station_if #(
    parameter int unsigned ROB_W = 5
);
    logic             rdy;
    logic             rollback_sign_from_rob;
    logic             enable_sign_from_dsp;
    logic [5:0]       opnum_from_dsp;
    logic [31:0]      V1_from_dsp;
    logic [31:0]      V2_from_dsp;
    logic [ROB_W-1:0] Q1_from_dsp;
    logic [ROB_W-1:0] Q2_from_dsp;
    logic [31:0]      pc_from_dsp;
    logic [31:0]      imm_from_dsp;
    logic [ROB_W-1:0] rob_id_from_dsp;
    logic             valid_sign_from_rs_ex;
    logic             valid_sign_from_ls_ex;
    logic [ROB_W-1:0] rob_id_from_rs_ex;
    logic [ROB_W-1:0] rob_id_from_ls_ex;
    logic [31:0]      data_from_rs_ex;
    logic [31:0]      data_from_ls_ex;
    logic             full_sign_to_fch;
    logic             enable_sign_to_ex;
    logic [5:0]       opnum_to_ex;
    logic [31:0]      V1_to_ex;
    logic [31:0]      V2_to_ex;
    logic [31:0]      pc_to_ex;
    logic [31:0]      imm_to_ex;
    logic [ROB_W-1:0] rob_id_to_ex;

    // Upstream side: dispatch, broadcasts and control in; issue out.
    modport master (
        output rdy, rollback_sign_from_rob, enable_sign_from_dsp, opnum_from_dsp,
               V1_from_dsp, V2_from_dsp, Q1_from_dsp, Q2_from_dsp, pc_from_dsp,
               imm_from_dsp, rob_id_from_dsp, valid_sign_from_rs_ex,
               valid_sign_from_ls_ex, rob_id_from_rs_ex, rob_id_from_ls_ex,
               data_from_rs_ex, data_from_ls_ex,
        input  full_sign_to_fch, enable_sign_to_ex, opnum_to_ex, V1_to_ex, V2_to_ex,
               pc_to_ex, imm_to_ex, rob_id_to_ex
    );

    modport slave (
        input  rdy, rollback_sign_from_rob, enable_sign_from_dsp, opnum_from_dsp,
               V1_from_dsp, V2_from_dsp, Q1_from_dsp, Q2_from_dsp, pc_from_dsp,
               imm_from_dsp, rob_id_from_dsp, valid_sign_from_rs_ex,
               valid_sign_from_ls_ex, rob_id_from_rs_ex, rob_id_from_ls_ex,
               data_from_rs_ex, data_from_ls_ex,
        output full_sign_to_fch, enable_sign_to_ex, opnum_to_ex, V1_to_ex, V2_to_ex,
               pc_to_ex, imm_to_ex, rob_id_to_ex
    );
endinterface

// File: rtl/reservation_station.sv
// Reservation station: tagged operand wait, CDB snoop, lowest-index dispatch and issue.
module reservation_station #(
    parameter int unsigned RS_SIZE = 16,
    parameter int unsigned ROB_W   = 5
) (
    input logic                  clk,
    input logic                  rst,
    reservation_station_if.slave bus
);
    localparam int unsigned IDX_W   = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
    localparam int unsigned CNT_W   = $clog2(RS_SIZE + 1);
    localparam int unsigned FULL_TH = RS_SIZE - 2;

    typedef struct packed {
        logic [ROB_W-1:0] q;
        logic [31:0]      v;
    } opnd_t;

    // Resolve a tagged operand against both broadcast ports; rs_ex wins a tie.
    function automatic opnd_t snoop(
        input logic [ROB_W-1:0] q,    input logic [31:0] v,
        input logic rs_v, input logic [ROB_W-1:0] rs_t, input logic [31:0] rs_d,
        input logic ls_v, input logic [ROB_W-1:0] ls_t, input logic [31:0] ls_d);
        opnd_t r;
        r.q = q;
        r.v = v;
        if (q != '0 && rs_v && q == rs_t) begin
            r.q = '0;
            r.v = rs_d;
        end else if (q != '0 && ls_v && q == ls_t) begin
            r.q = '0;
            r.v = ls_d;
        end
        return r;
    endfunction

    logic [RS_SIZE-1:0] busy_q, busy_d;
    logic [5:0]         op_q  [RS_SIZE];
    logic [5:0]         op_d  [RS_SIZE];
    logic [31:0]        v1_q  [RS_SIZE];
    logic [31:0]        v1_d  [RS_SIZE];
    logic [31:0]        v2_q  [RS_SIZE];
    logic [31:0]        v2_d  [RS_SIZE];
    logic [31:0]        pc_q  [RS_SIZE];
    logic [31:0]        pc_d  [RS_SIZE];
    logic [31:0]        imm_q [RS_SIZE];
    logic [31:0]        imm_d [RS_SIZE];
    logic [ROB_W-1:0]   q1_q  [RS_SIZE];
    logic [ROB_W-1:0]   q1_d  [RS_SIZE];
    logic [ROB_W-1:0]   q2_q  [RS_SIZE];
    logic [ROB_W-1:0]   q2_d  [RS_SIZE];
    logic [ROB_W-1:0]   rob_q [RS_SIZE];
    logic [ROB_W-1:0]   rob_d [RS_SIZE];

    logic [CNT_W-1:0]   count_q, count_d;
    logic               en_q, en_d;
    logic [5:0]         op_ex_q, op_ex_d;
    logic [31:0]        v1_ex_q, v1_ex_d, v2_ex_q, v2_ex_d;
    logic [31:0]        pc_ex_q, pc_ex_d, imm_ex_q, imm_ex_d;
    logic [ROB_W-1:0]   rob_ex_q, rob_ex_d;

    logic               free_found, iss_found, dsp_ok;
    logic [IDX_W-1:0]   free_idx, iss_idx;
    opnd_t              snp1 [RS_SIZE];
    opnd_t              snp2 [RS_SIZE];
    opnd_t              in1, in2;

    // Lowest free slot and lowest ready slot, both from start-of-cycle state.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        iss_found  = 1'b0;
        iss_idx    = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (busy_q[i] && q1_q[i] == '0 && q2_q[i] == '0) begin
                iss_found = 1'b1;
                iss_idx   = IDX_W'(i);
            end
        end
    end

    assign dsp_ok = bus.enable_sign_from_dsp & free_found;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            snp1[i] = snoop(q1_q[i], v1_q[i],
                            bus.valid_sign_from_rs_ex, bus.rob_id_from_rs_ex, bus.data_from_rs_ex,
                            bus.valid_sign_from_ls_ex, bus.rob_id_from_ls_ex, bus.data_from_ls_ex);
            snp2[i] = snoop(q2_q[i], v2_q[i],
                            bus.valid_sign_from_rs_ex, bus.rob_id_from_rs_ex, bus.data_from_rs_ex,
                            bus.valid_sign_from_ls_ex, bus.rob_id_from_ls_ex, bus.data_from_ls_ex);
        end
        in1 = snoop(bus.Q1_from_dsp, bus.V1_from_dsp,
                    bus.valid_sign_from_rs_ex, bus.rob_id_from_rs_ex, bus.data_from_rs_ex,
                    bus.valid_sign_from_ls_ex, bus.rob_id_from_ls_ex, bus.data_from_ls_ex);
        in2 = snoop(bus.Q2_from_dsp, bus.V2_from_dsp,
                    bus.valid_sign_from_rs_ex, bus.rob_id_from_rs_ex, bus.data_from_rs_ex,
                    bus.valid_sign_from_ls_ex, bus.rob_id_from_ls_ex, bus.data_from_ls_ex);
    end

    // Next state: rollback beats rdy; rdy low holds everything.
    always_comb begin
        busy_d   = busy_q;
        op_d     = op_q;
        v1_d     = v1_q;
        v2_d     = v2_q;
        pc_d     = pc_q;
        imm_d    = imm_q;
        q1_d     = q1_q;
        q2_d     = q2_q;
        rob_d    = rob_q;
        count_d  = count_q;
        en_d     = en_q;
        op_ex_d  = op_ex_q;
        v1_ex_d  = v1_ex_q;
        v2_ex_d  = v2_ex_q;
        pc_ex_d  = pc_ex_q;
        imm_ex_d = imm_ex_q;
        rob_ex_d = rob_ex_q;
        if (bus.rollback_sign_from_rob) begin
            busy_d  = '0;
            count_d = '0;
            en_d    = 1'b0;
        end else if (bus.rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i]) begin
                    q1_d[i] = snp1[i].q;
                    v1_d[i] = snp1[i].v;
                    q2_d[i] = snp2[i].q;
                    v2_d[i] = snp2[i].v;
                end
            end
            en_d = iss_found;
            if (iss_found) begin
                busy_d[iss_idx] = 1'b0;
                op_ex_d  = op_q[iss_idx];
                v1_ex_d  = v1_q[iss_idx];
                v2_ex_d  = v2_q[iss_idx];
                pc_ex_d  = pc_q[iss_idx];
                imm_ex_d = imm_q[iss_idx];
                rob_ex_d = rob_q[iss_idx];
            end
            if (dsp_ok) begin
                busy_d[free_idx] = 1'b1;
                op_d[free_idx]   = bus.opnum_from_dsp;
                v1_d[free_idx]   = in1.v;
                q1_d[free_idx]   = in1.q;
                v2_d[free_idx]   = in2.v;
                q2_d[free_idx]   = in2.q;
                pc_d[free_idx]   = bus.pc_from_dsp;
                imm_d[free_idx]  = bus.imm_from_dsp;
                rob_d[free_idx]  = bus.rob_id_from_dsp;
            end
            count_d = count_q + CNT_W'(dsp_ok) - CNT_W'(iss_found);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= '0;
            count_q  <= '0;
            en_q     <= 1'b0;
            op_ex_q  <= '0;
            v1_ex_q  <= '0;
            v2_ex_q  <= '0;
            pc_ex_q  <= '0;
            imm_ex_q <= '0;
            rob_ex_q <= '0;
        end else begin
            busy_q   <= busy_d;
            count_q  <= count_d;
            en_q     <= en_d;
            op_ex_q  <= op_ex_d;
            v1_ex_q  <= v1_ex_d;
            v2_ex_q  <= v2_ex_d;
            pc_ex_q  <= pc_ex_d;
            imm_ex_q <= imm_ex_d;
            rob_ex_q <= rob_ex_d;
        end
    end

    // Entry payload is qualified by busy, so it carries no reset.
    always_ff @(posedge clk) begin
        op_q  <= op_d;
        v1_q  <= v1_d;
        v2_q  <= v2_d;
        pc_q  <= pc_d;
        imm_q <= imm_d;
        q1_q  <= q1_d;
        q2_q  <= q2_d;
        rob_q <= rob_d;
    end

    assign bus.full_sign_to_fch  = (count_q >= CNT_W'(FULL_TH));
    assign bus.enable_sign_to_ex = en_q;
    assign bus.opnum_to_ex       = op_ex_q;
    assign bus.V1_to_ex          = v1_ex_q;
    assign bus.V2_to_ex          = v2_ex_q;
    assign bus.pc_to_ex          = pc_ex_q;
    assign bus.imm_to_ex         = imm_ex_q;
    assign bus.rob_id_to_ex      = rob_ex_q;
endmodule

// File: tb/tb_reservation_station.sv
// Random plus directed bench for reservation_station against a table-level reference model.
module tb_reservation_station;
    localparam int unsigned RS_SIZE = 16;
    localparam int unsigned ROB_W   = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reservation_station_if #(.ROB_W(ROB_W)) bus ();

    reservation_station #(.RS_SIZE(RS_SIZE), .ROB_W(ROB_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        bit        busy;
        bit [5:0]  op;
        bit [31:0] v1, v2, pc, imm;
        bit [4:0]  q1, q2, rob;
    } ent_t;

    ent_t      m [RS_SIZE];
    bit        m_en;
    bit [5:0]  m_op;
    bit [31:0] m_v1, m_v2, m_pc, m_imm;
    bit [4:0]  m_rob;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int occupancy();
        int n = 0;
        for (int i = 0; i < RS_SIZE; i++) if (m[i].busy) n++;
        return n;
    endfunction

    // An operand waiting on tag q picks up a matching broadcast, rs_ex first.
    function automatic bit [36:0] cdb(input bit [4:0] q, input bit [31:0] v);
        if (q != 0 && bus.valid_sign_from_rs_ex && q == bus.rob_id_from_rs_ex)
            return {5'd0, bus.data_from_rs_ex};
        if (q != 0 && bus.valid_sign_from_ls_ex && q == bus.rob_id_from_ls_ex)
            return {5'd0, bus.data_from_ls_ex};
        return {q, v};
    endfunction

    task automatic model_step();
        ent_t nx [RS_SIZE];
        int   iss = -1;
        int   fr  = -1;
        if (rst) begin
            for (int i = 0; i < RS_SIZE; i++) m[i].busy = 1'b0;
            m_en = 0; m_op = 0; m_v1 = 0; m_v2 = 0; m_pc = 0; m_imm = 0; m_rob = 0;
            return;
        end
        if (bus.rollback_sign_from_rob) begin
            for (int i = 0; i < RS_SIZE; i++) m[i].busy = 1'b0;
            m_en = 0;
            return;
        end
        if (!bus.rdy) return;
        nx = m;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (iss < 0 && m[i].busy && m[i].q1 == 0 && m[i].q2 == 0) iss = i;
            if (fr < 0 && !m[i].busy) fr = i;
            if (m[i].busy) begin
                {nx[i].q1, nx[i].v1} = cdb(m[i].q1, m[i].v1);
                {nx[i].q2, nx[i].v2} = cdb(m[i].q2, m[i].v2);
            end
        end
        m_en = (iss >= 0);
        if (iss >= 0) begin
            m_op = m[iss].op; m_v1 = m[iss].v1; m_v2 = m[iss].v2;
            m_pc = m[iss].pc; m_imm = m[iss].imm; m_rob = m[iss].rob;
            nx[iss].busy = 1'b0;
        end
        if (bus.enable_sign_from_dsp && fr >= 0) begin
            nx[fr].busy = 1'b1;
            nx[fr].op   = bus.opnum_from_dsp;
            nx[fr].pc   = bus.pc_from_dsp;
            nx[fr].imm  = bus.imm_from_dsp;
            nx[fr].rob  = bus.rob_id_from_dsp;
            {nx[fr].q1, nx[fr].v1} = cdb(bus.Q1_from_dsp, bus.V1_from_dsp);
            {nx[fr].q2, nx[fr].v2} = cdb(bus.Q2_from_dsp, bus.V2_from_dsp);
        end
        m = nx;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("en",   32'(bus.enable_sign_to_ex), 32'(m_en));
        check("op",   32'(bus.opnum_to_ex),       32'(m_op));
        check("v1",   bus.V1_to_ex,               m_v1);
        check("v2",   bus.V2_to_ex,               m_v2);
        check("pc",   bus.pc_to_ex,               m_pc);
        check("imm",  bus.imm_to_ex,              m_imm);
        check("rob",  32'(bus.rob_id_to_ex),      32'(m_rob));
        check("full", 32'(bus.full_sign_to_fch),  32'(occupancy() >= RS_SIZE - 2));
    endtask

    task automatic idle();
        rst = 1'b0;
        bus.rdy = 1'b1;
        bus.rollback_sign_from_rob = 1'b0;
        bus.enable_sign_from_dsp = 1'b0;
        bus.valid_sign_from_rs_ex = 1'b0;
        bus.valid_sign_from_ls_ex = 1'b0;
    endtask

    task automatic disp(input bit [5:0] op, input bit [31:0] v1, input bit [31:0] v2,
                        input bit [4:0] q1, input bit [4:0] q2, input bit [4:0] rob);
        bus.enable_sign_from_dsp = 1'b1;
        bus.opnum_from_dsp = op;
        bus.V1_from_dsp = v1;
        bus.V2_from_dsp = v2;
        bus.Q1_from_dsp = q1;
        bus.Q2_from_dsp = q2;
        bus.rob_id_from_dsp = rob;
        bus.pc_from_dsp = $urandom;
        bus.imm_from_dsp = $urandom;
    endtask

    task automatic bcast(input bit rs, input bit [4:0] tag, input bit [31:0] data);
        if (rs) begin
            bus.valid_sign_from_rs_ex = 1'b1;
            bus.rob_id_from_rs_ex = tag;
            bus.data_from_rs_ex = data;
        end else begin
            bus.valid_sign_from_ls_ex = 1'b1;
            bus.rob_id_from_ls_ex = tag;
            bus.data_from_ls_ex = data;
        end
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cycle();
        cycle();
        idle();
    endtask

    function automatic bit [4:0] pick_tag();
        for (int t = 0; t < 4; t++) begin
            int i = $urandom_range(0, RS_SIZE - 1);
            if (m[i].busy && m[i].q1 != 0) return m[i].q1;
            if (m[i].busy && m[i].q2 != 0) return m[i].q2;
        end
        return 5'($urandom_range(1, 31));
    endfunction

    initial begin
        int  n_iss;
        bit  saw31;
        idle();
        bus.opnum_from_dsp = '0; bus.V1_from_dsp = '0; bus.V2_from_dsp = '0;
        bus.Q1_from_dsp = '0; bus.Q2_from_dsp = '0; bus.pc_from_dsp = '0;
        bus.imm_from_dsp = '0; bus.rob_id_from_dsp = '0;
        bus.rob_id_from_rs_ex = '0; bus.rob_id_from_ls_ex = '0;
        bus.data_from_rs_ex = '0; bus.data_from_ls_ex = '0;
        do_reset();
        check("rst_en",   32'(bus.enable_sign_to_ex), 32'd0);
        check("rst_v1",   bus.V1_to_ex, 32'd0);
        check("rst_full", 32'(bus.full_sign_to_fch), 32'd0);

        // Ready-at-dispatch op issues on the next edge.
        disp(6'd1, 32'd5, 32'd7, 5'd0, 5'd0, 5'd3); cycle(); idle(); cycle();
        check("r19_en", 32'(bus.enable_sign_to_ex), 32'd1);
        check("r19_v1", bus.V1_to_ex, 32'd5);
        check("r19_v2", bus.V2_to_ex, 32'd7);
        check("r19_rob", 32'(bus.rob_id_to_ex), 32'd3);

        // Wakeup by rs_ex broadcast, issue one edge later.
        disp(6'd2, 32'd0, 32'h22, 5'd4, 5'd0, 5'd8); cycle(); idle(); cycle(); cycle();
        bcast(1'b1, 5'd4, 32'h10); cycle();
        check("r20_wait", 32'(bus.enable_sign_to_ex), 32'd0);
        idle(); cycle();
        check("r20_en", 32'(bus.enable_sign_to_ex), 32'd1);
        check("r20_v1", bus.V1_to_ex, 32'h10);
        check("r20_rob", 32'(bus.rob_id_to_ex), 32'd8);

        // Insert forwarding from ls_ex.
        disp(6'd3, 32'd1, 32'd0, 5'd0, 5'd6, 5'd9); bcast(1'b0, 5'd6, 32'd9); cycle();
        idle(); cycle();
        check("r21_en", 32'(bus.enable_sign_to_ex), 32'd1);
        check("r21_v2", bus.V2_to_ex, 32'd9);
        check("r21_rob", 32'(bus.rob_id_to_ex), 32'd9);

        // Fill, full hint, overflow drop.
        do_reset();
        for (int k = 0; k < 14; k++) begin
            disp(6'd4, 32'(k), 32'(k), 5'd7, 5'd0, 5'(k + 1)); cycle();
            if (k == 12) check("r22_notfull", 32'(bus.full_sign_to_fch), 32'd0);
        end
        check("r22_full", 32'(bus.full_sign_to_fch), 32'd1);
        disp(6'd4, 32'd0, 32'd0, 5'd7, 5'd0, 5'd20); cycle();
        disp(6'd4, 32'd0, 32'd0, 5'd7, 5'd0, 5'd21); cycle();
        disp(6'd4, 32'd0, 32'd0, 5'd0, 5'd0, 5'd31); cycle();
        check("r22_count", 32'(dut.count_q), 32'd16);
        idle(); bcast(1'b1, 5'd7, 32'hABC); cycle(); idle();
        n_iss = 0; saw31 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (bus.enable_sign_to_ex) begin
                n_iss++;
                if (bus.rob_id_to_ex == 5'd31) saw31 = 1'b1;
            end
        end
        check("r22_issued", 32'(n_iss), 32'd16);
        check("r22_dropped", 32'(saw31), 32'd0);

        // Rollback beats same-cycle dispatch.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            disp(6'd5, 32'd0, 32'd0, 5'd9, 5'd0, 5'(k + 1)); cycle();
        end
        disp(6'd5, 32'd1, 32'd1, 5'd0, 5'd0, 5'd30); bus.rollback_sign_from_rob = 1'b1; cycle();
        check("r23_count", 32'(dut.count_q), 32'd0);
        check("r23_full", 32'(bus.full_sign_to_fch), 32'd0);
        idle(); bcast(1'b1, 5'd9, 32'd1); cycle();
        check("r23_noiss", 32'(bus.enable_sign_to_ex), 32'd0);
        idle(); cycle();
        check("r23_noiss2", 32'(bus.enable_sign_to_ex), 32'd0);

        // Two entries wake together; lower index first, rdy=0 holds outputs.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            disp(6'd6, 32'(k), 32'(k), (k == 2 || k == 5) ? 5'd11 : 5'd12, 5'd0, 5'(k + 1));
            cycle();
        end
        idle(); bcast(1'b0, 5'd11, 32'h55); cycle();
        idle(); cycle();
        check("r24_first", 32'(bus.rob_id_to_ex), 32'd3);
        bus.rdy = 1'b0; cycle(); cycle();
        check("r24_hold_en", 32'(bus.enable_sign_to_ex), 32'd1);
        check("r24_hold_rob", 32'(bus.rob_id_to_ex), 32'd3);
        bus.rdy = 1'b1; cycle();
        check("r24_second", 32'(bus.rob_id_to_ex), 32'd6);
        check("r24_v1", bus.V1_to_ex, 32'h55);
        cycle();
        check("r24_none", 32'(bus.enable_sign_to_ex), 32'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            idle();
            rst = ($urandom_range(0, 499) == 0);
            bus.rollback_sign_from_rob = ($urandom_range(0, 99) == 0);
            bus.rdy = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) < 6)
                disp(6'($urandom), $urandom, $urandom,
                     ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                     ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                     5'($urandom_range(1, 31)));
            if ($urandom_range(0, 1) == 1) bcast(1'b1, pick_tag(), $urandom);
            if ($urandom_range(0, 1) == 1) bcast(1'b0, pick_tag(), $urandom);
            if ($urandom_range(0, 4) == 0 && bus.enable_sign_from_dsp)
                bcast(1'b1, bus.Q1_from_dsp, $urandom);
            if ($urandom_range(0, 7) == 0 && bus.valid_sign_from_rs_ex)
                bcast(1'b0, bus.rob_id_from_rs_ex, $urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
